// File: rtl/cpu_commit_trace_buffer.sv
`default_nettype none
// ==========================================================================
// cpu_commit_trace_buffer : commit-record FIFO with in-band overflow markers
// Optional macro CPU_TRACE_TIMESTAMP_EN prepends a 32-bit cycle stamp. Rev 1.0
// ==========================================================================
module cpu_commit_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
`ifdef CPU_TRACE_TIMESTAMP_EN
  , localparam int TW = 200
`else
  , localparam int TW = 168
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trace_en,
  input  logic             commit_valid,
  input  logic [31:0]      commit_pc,
  input  logic [31:0]      commit_instr,
  input  logic             commit_rd_we,
  input  logic [4:0]       commit_rd,
  input  logic [31:0]      commit_rd_wdata,
  input  logic             commit_mem_we,
  input  logic [31:0]      commit_mem_addr,
  input  logic [31:0]      commit_mem_wdata,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [TW-1:0]    trace_data,
  output logic             trace_full,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int RW = 168;

  localparam logic [1:0] S_OFF      = 2'd0;
  localparam logic [1:0] S_CAPTURE  = 2'd1;
  localparam logic [1:0] S_OVERFLOW = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [TW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]    count_q;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] episode_q, episode_d;
  logic [CNT_W-1:0] episode_inc, mark_ep;

  logic          empty, full, pop, space;
  logic          push_rec, push_mark, drop, push;
  logic [RW-1:0] rec_w, mark_w;
  logic [TW-1:0] push_data;

  assign empty       = (count_q == '0);
  assign full        = (count_q == OW'(DEPTH));
  assign trace_valid = !empty;
  assign trace_full  = full;
  assign pop         = trace_valid & trace_ready;
  // A slot freed by a same-cycle pop is usable by this cycle's push.
  assign space       = !full | pop;
  assign push        = push_rec | push_mark;
  assign drop_cnt    = drop_cnt_q;

  assign episode_inc = (&episode_q) ? episode_q : episode_q + 1'b1;
  assign mark_ep     = commit_valid ? episode_inc : episode_q;
  assign drop_cnt_d  = (drop && !(&drop_cnt_q)) ? drop_cnt_q + 1'b1 : drop_cnt_q;

  assign rec_w  = {1'b0, commit_pc, commit_instr, commit_rd_we, commit_rd,
                   commit_rd_wdata, commit_mem_we, commit_mem_addr, commit_mem_wdata};
  assign mark_w = {1'b1, 32'd0, 32'd0, 1'b0, 5'd0, 32'(mark_ep), 1'b0, 32'd0, 32'd0};

`ifdef CPU_TRACE_TIMESTAMP_EN
  logic [31:0] cycle_q;

  always_ff @(posedge clk) begin
    if (rst) cycle_q <= '0;
    else     cycle_q <= cycle_q + 1'b1;
  end

  assign push_data = {cycle_q, (push_mark ? mark_w : rec_w)};
`else
  assign push_data = push_mark ? mark_w : rec_w;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_OFF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:      if (trace_en) state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (commit_valid && !space) state_d = S_OVERFLOW;
        else if (!trace_en)         state_d = S_OFF;
      end
      S_OVERFLOW: if (space) state_d = trace_en ? S_CAPTURE : S_OFF;
      default:    state_d = S_OFF;
    endcase
  end

  // In OVERFLOW every commit is dropped; a free slot goes to the marker.
  always_comb begin
    push_rec  = 1'b0;
    push_mark = 1'b0;
    drop      = 1'b0;
    case (state_q)
      S_CAPTURE: begin
        push_rec = commit_valid & space;
        drop     = commit_valid & !space;
      end
      S_OVERFLOW: begin
        drop      = commit_valid;
        push_mark = space;
      end
      default: ;
    endcase
  end

  always_comb begin
    episode_d = episode_q;
    if (state_q == S_CAPTURE && drop) episode_d = CNT_W'(1);
    else if (push_mark)               episode_d = '0;
    else if (drop)                    episode_d = episode_inc;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      episode_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      drop_cnt_q <= drop_cnt_d;
      episode_q  <= episode_d;
    end
  end

  assign trace_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire
